// File: rtl/eb_multi_slot_if.sv
// Handshake bundle for the multi-slot elastic buffer.
// slave = buffer side, master = side driving data in and draining the head.
interface eb_multi_slot_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  valid_in;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_out;
  logic                  ready_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic [CW-1:0]         count;
  logic                  almost_full;

  modport slave (
    input  flush, valid_in, data_in, ready_in,
    output ready_out, valid_out, data_out, count, almost_full
  );

  modport master (
    output flush, valid_in, data_in, ready_in,
    input  ready_out, valid_out, data_out, count, almost_full
  );
endinterface

// File: rtl/eb_multi_slot.sv
// DEPTH-slot FIFO elastic buffer: one head register drives data_out directly,
// DEPTH-1 circular aux slots sit behind it. ready_out/almost_full are
// registered from the next-state count, so ready_in never reaches ready_out.
module eb_multi_slot #(
  parameter int   DATA_WIDTH      = 16,
  parameter int   DEPTH           = 4,
  parameter int   AFULL_THRESH    = 3,
  parameter logic GATING_FRIENDLY = 1'b1
) (
  input logic             clk,
  input logic             rst,
  eb_multi_slot_if.slave  bus
);
  localparam int AUX = DEPTH - 1;
  localparam int AW  = (AUX > 1) ? $clog2(AUX) : 1;
  localparam int ACW = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("eb_multi_slot: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("eb_multi_slot: AFULL_THRESH must be in 1..DEPTH");
  end

  logic                          vld_q, rdy_q, afull_q;
  logic [CW-1:0]                 cnt_q, cnt_nxt;
  logic [DATA_WIDTH-1:0]         head_q, head_d;
  logic [AUX-1:0][DATA_WIDTH-1:0] aux_q;
  logic [AW-1:0]                 rd_ptr, wr_ptr;
  logic [ACW-1:0]                aux_cnt;
  logic                          push, pop, aux_empty, aux_full;
  logic                          head_ld, head_en, vld_nxt, aux_wr, aux_rd;
  logic [AUX-1:0]                aux_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(AUX - 1)) ? '0 : p + AW'(1);
  endfunction

  // Steer each accepted item to the head or the aux ring, and refill the head on pop.
  always_comb begin
    push      = bus.valid_in & rdy_q;
    pop       = vld_q & bus.ready_in;
    aux_empty = (aux_cnt == '0);
    aux_full  = (aux_cnt == ACW'(AUX));
    head_ld   = 1'b0;
    head_d    = bus.data_in;
    vld_nxt   = vld_q;
    aux_wr    = 1'b0;
    aux_rd    = 1'b0;
    if (!vld_q || (pop && aux_empty)) begin
      // head free (or freed with nothing behind it): data_in bypasses the ring
      head_ld = push;
      vld_nxt = push;
    end else if (pop) begin
      head_ld = 1'b1;
      head_d  = aux_q[rd_ptr];
      aux_rd  = 1'b1;
      aux_wr  = push;
    end else begin
      aux_wr  = push;
    end
    cnt_nxt = cnt_q + CW'(push) - CW'(pop);
    // with gating off, an idle head simply tracks data_in
    head_en = head_ld | (~GATING_FRIENDLY & ~vld_nxt);
    for (int i = 0; i < AUX; i++) begin
      // with gating off, the free slot at wr_ptr may load every cycle
      aux_en[i] = (wr_ptr == AW'(i)) & (aux_wr | (~GATING_FRIENDLY & ~aux_full));
    end
  end

  // Control state: flags, count and ring pointers; flush clears, reset wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
      afull_q <= 1'b0;
      cnt_q   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      aux_cnt <= '0;
    end else if (bus.flush) begin
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
      afull_q <= 1'b0;
      cnt_q   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      aux_cnt <= '0;
    end else begin
      vld_q   <= vld_nxt;
      rdy_q   <= (cnt_nxt < CW'(DEPTH));
      afull_q <= (cnt_nxt >= CW'(AFULL_THRESH));
      cnt_q   <= cnt_nxt;
      if (aux_rd) rd_ptr <= ptr_inc(rd_ptr);
      if (aux_wr) wr_ptr <= ptr_inc(wr_ptr);
      aux_cnt <= aux_cnt + ACW'(aux_wr) - ACW'(aux_rd);
    end
  end

  // Head data register; cleared on reset so data_out starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          head_q <= '0;
    else if (head_en) head_q <= head_d;
  end

  // Aux ring storage; contents are don't-care until counted in aux_cnt.
  always_ff @(posedge clk) begin
    for (int i = 0; i < AUX; i++)
      if (aux_en[i]) aux_q[i] <= bus.data_in;
  end

  assign bus.valid_out   = vld_q;
  assign bus.ready_out   = rdy_q;
  assign bus.data_out    = head_q;
  assign bus.count       = cnt_q;
  assign bus.almost_full = afull_q;
endmodule

// File: tb/tb_eb_multi_slot.sv
// Directed + random bench for eb_multi_slot (DEPTH=4, AFULL_THRESH=3).
module tb_eb_multi_slot;
  localparam int DW = 16, DEPTH = 4, AF = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eb_multi_slot_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus();

  eb_multi_slot #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF), .GATING_FRIENDLY(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0, bad = 0;
  int n_push = 0, n_pop = 0, full_pop = 0;
  logic [DW-1:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // drive one cycle, advance the reference queue across the edge
  task automatic cyc(input logic vin, input logic [DW-1:0] din, input logic rin, input logic fl);
    logic mp, mq;
    bus.valid_in = vin; bus.data_in = din; bus.ready_in = rin; bus.flush = fl;
    mp = vin && (q.size() < DEPTH);
    mq = rin && (q.size() > 0);
    if (mq && q.size() == DEPTH && !fl) full_pop++;
    @(posedge clk); #1;
    if (fl) q.delete();
    else begin
      if (mq) begin void'(q.pop_front()); n_pop++; end
      if (mp) begin q.push_back(din); n_push++; end
    end
  endtask

  task automatic mchk();
    chk("m_valid", bus.valid_out, q.size() > 0);
    chk("m_ready", bus.ready_out, q.size() < DEPTH);
    chk("m_count", bus.count, q.size());
    chk("m_afull", bus.almost_full, q.size() >= AF);
    if (q.size() > 0) chk("m_data", bus.data_out, q[0]);
  endtask

  initial begin
    int ncyc;
    bus.valid_in = 0; bus.data_in = '0; bus.ready_in = 0; bus.flush = 0;
    // 1. reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_ready", bus.ready_out, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_afull", bus.almost_full, 0);
    chk("rst_data", bus.data_out, 0);
    rst = 0;

    // 2. fill to full with no drain, then drain
    cyc(1, 16'hA1, 0, 0);
    chk("f1_count", bus.count, 1); chk("f1_valid", bus.valid_out, 1);
    chk("f1_data", bus.data_out, 16'hA1); chk("f1_afull", bus.almost_full, 0);
    cyc(1, 16'hA2, 0, 0);
    chk("f2_count", bus.count, 2); chk("f2_afull", bus.almost_full, 0);
    cyc(1, 16'hA3, 0, 0);
    chk("f3_count", bus.count, 3); chk("f3_afull", bus.almost_full, 1);
    chk("f3_ready", bus.ready_out, 1);
    cyc(1, 16'hA4, 0, 0);
    chk("f4_count", bus.count, 4); chk("f4_ready", bus.ready_out, 0);
    cyc(1, 16'hA5, 0, 0);
    chk("f5_count", bus.count, 4); chk("f5_data", bus.data_out, 16'hA1);
    chk("f5_ready", bus.ready_out, 0);
    cyc(0, 16'h0, 1, 0);
    chk("d1_data", bus.data_out, 16'hA2); chk("d1_count", bus.count, 3);
    chk("d1_ready", bus.ready_out, 1); chk("d1_afull", bus.almost_full, 1);
    cyc(0, 16'h0, 1, 0);
    chk("d2_data", bus.data_out, 16'hA3); chk("d2_afull", bus.almost_full, 0);
    cyc(0, 16'h0, 1, 0);
    chk("d3_data", bus.data_out, 16'hA4); chk("d3_count", bus.count, 1);
    cyc(0, 16'h0, 1, 0);
    chk("d4_valid", bus.valid_out, 0); chk("d4_count", bus.count, 0);

    // 3. streaming: head follows data_in by one cycle, count stays 1
    for (int k = 0; k < 20; k++) begin
      cyc(1, 16'(16'h100 + k), 1, 0);
      chk("st_data", bus.data_out, 16'h100 + k);
      chk("st_count", bus.count, 1);
      chk("st_valid", bus.valid_out, 1);
    end
    cyc(0, 16'h0, 1, 0);
    chk("st_end_valid", bus.valid_out, 0);

    // 4. random traffic against the reference queue
    n_push = 0; n_pop = 0; full_pop = 0; ncyc = 0;
    while (n_push < 1000 && ncyc < 20000) begin
      logic vin, rin;
      vin = ($urandom_range(0, 99) < 70);
      rin = ($urandom_range(0, 99) < (((ncyc / 100) % 2) ? 85 : 25));
      cyc(vin, 16'(n_push), rin, 0);
      mchk();
      ncyc++;
    end
    for (int k = 0; k < 10; k++) begin
      cyc(0, 16'h0, 1, 0);
      mchk();
    end
    chk("rand_pushed", n_push, 1000);
    chk("rand_popped", n_pop, 1000);
    chk("rand_full_drain_seen", full_pop > 0, 1);

    // 5. flush with concurrent push and pop
    cyc(1, 16'hB1, 0, 0); cyc(1, 16'hB2, 0, 0); cyc(1, 16'hB3, 0, 0);
    chk("fl_pre_count", bus.count, 3);
    cyc(1, 16'hBB, 1, 1);
    chk("fl_count", bus.count, 0); chk("fl_valid", bus.valid_out, 0);
    chk("fl_ready", bus.ready_out, 1); chk("fl_afull", bus.almost_full, 0);
    cyc(1, 16'h55, 0, 0);
    chk("fl_p_data", bus.data_out, 16'h55); chk("fl_p_count", bus.count, 1);
    chk("fl_p_valid", bus.valid_out, 1);
    cyc(0, 16'h0, 1, 0);
    chk("fl_alone_valid", bus.valid_out, 0); chk("fl_alone_count", bus.count, 0);

    // 6. asynchronous reset between edges
    cyc(1, 16'h70, 1, 0);
    cyc(1, 16'h71, 0, 0);
    chk("ar_pre_count", bus.count, 2);
    #2 rst = 1;
    #1;
    chk("ar_valid", bus.valid_out, 0); chk("ar_ready", bus.ready_out, 1);
    chk("ar_count", bus.count, 0); chk("ar_afull", bus.almost_full, 0);
    chk("ar_data", bus.data_out, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 0;
    cyc(1, 16'h77, 0, 0);
    chk("ar_post_data", bus.data_out, 16'h77); chk("ar_post_count", bus.count, 1);
    cyc(0, 16'h0, 1, 0);
    chk("ar_post_valid", bus.valid_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
